rs_station_multi: RTL
=====================

Name: rs_station_multi

Overview:
- Parametrised successor to the single-issue ALU reservation station.
- Holds up to DEPTH decoded instructions waiting for operands and snoops NUM_CDB result broadcast channels, e.g. ALU, LSB and a second ALU.
- Issues the oldest ready entry through a registered valid/ready port to a functional unit.
- Sits between dispatch and the ALUs. Allocation is internal: dispatch no longer supplies a slot index.

Parameters:
- DEPTH, 16, number of entries; must be at least 2.
- XLEN, 32, operand, immediate and PC width.
- OP_W, 6, opcode width.
- TAG_W, 4, ROB tag width.
- NUM_CDB, 2, number of result broadcast channels.
- IDX_W, $clog2(DEPTH), entry index and age width.
- CNT_W, $clog2(DEPTH+1), occupancy count width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  global enable; low freezes all state.
- clear  in  1  synchronous flush on branch mispredict.
- push_valid  in  1  dispatch request.
- push_accept  out  1  combinational; equals (count != DEPTH) && ready && !clear.
- push_op / push_imm / push_pc  in  OP_W / XLEN / XLEN  instruction fields.
- push_robpos  in  TAG_W  destination ROB tag.
- push_vj / push_vk  in  XLEN  operand value, or the producing tag in bits [TAG_W-1:0] when the operand is pending.
- push_qj / push_qk  in  1  1 = operand pending.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  flattened tags; channel c occupies bits [c*TAG_W +: TAG_W].
- cdb_val  in  NUM_CDB*XLEN  flattened values.
- iss_valid  out  1  registered; issue register holds an instruction.
- iss_ready  in  1  functional unit accepts.
- iss_op / iss_imm / iss_pc / iss_robpos / iss_vj / iss_vk  out  as push  registered issue fields.
- count  out  CNT_W  registered occupancy; excludes the issue register.
- full  out  1  registered; count == DEPTH.

Behaviour:
- Reset (reset low, asynchronous): all entries free, count = 0, full = 0, iss_valid = 0. Issue data fields are 0.
- Reset released mid-operation: the next edge behaves as a fresh start; no partial state survives.
- Precedence at each edge: reset, then clear, then ready.
- clear (when ready is ignored): empties all entries, count = 0, full = 0, iss_valid = 0; push is ignored that cycle.
- ready low: nothing changes, including issue register and count. Upstream guarantees no cdb_valid, push or handshake while ready is low.

Allocation:
- Push is accepted when push_valid && push_accept.
- The entry goes to the lowest-index free slot.
- Push while full is dropped with no side effects, even if an issue frees a slot in the same cycle.

Wakeup:
- For every busy entry with a pending operand, a tag match on any valid channel clears the q bit and writes the channel's value at the edge.
- If several channels match, the lowest channel index wins.
- Push bypass: a pending push operand that matches a same-cycle broadcast is stored as ready with the broadcast value.

Age and selection:
- Each entry carries an IDX_W age. A pushed entry gets age 0; every other busy entry increments at that edge.
- Ages of busy entries stay distinct and below DEPTH.
- Selection is combinational: the busy entry with both q bits 0 and the maximum age, i.e. the oldest ready entry.

Issue:
- The issue register loads when a selectable entry exists and (!iss_valid || iss_ready).
- On load, the entry is freed at the same edge and iss_valid is 1 on the next cycle.
- If (iss_valid && iss_ready) and nothing is selectable, iss_valid goes to 0.
- Fields stay stable while iss_valid && !iss_ready.

Latency:
- An entry pushed ready at edge P appears on iss_* after edge P+1.
- A broadcast at edge W makes a waiting entry issuable; it appears after edge W+1.
- A wakeup and selection of the same entry never coincide in one cycle.

Count:
- count_next = count + push_accepted - issue_load; both can occur in one cycle.
- full = (count_next == DEPTH).

Test Plan:
1. Reset low mid-stream with 5 entries busy and iss_valid = 1 → immediately count = 0, full = 0, iss_valid = 0. After release, a ready push is issued 2 edges later.
2. Push A (op 3, vj 10, vk 20, qj = qk = 0, robpos 5) with iss_ready = 1 → iss_valid = 1 one cycle later with iss_vj = 10, iss_vk = 20, iss_robpos = 5; count returns to 0.
3. Push B with qj = 1, tag 7. Broadcast tag 7, value 0xDEAD on channel 1 two cycles later → B issues the following cycle with iss_vj = 0xDEAD. Repeat with the broadcast in the same cycle as the push → B is stored ready and issues one cycle after the push.
4. Fill all 16 entries with pending operands → full = 1 and push_accept = 0; a 17th push is dropped. Wake entries pushed 3rd and 9th in one broadcast → the 3rd issues first, then the 9th.
5. Hold iss_ready = 0 with 3 ready entries → iss_* stays stable and count stays at 2. Then set iss_ready = 1 → one issue per cycle, oldest first.
6. Assert clear while 4 entries are busy and a push and broadcast are active → next cycle count = 0, iss_valid = 0, and the push is not stored.

Source files
------------

// File: rtl/rs_station_multi.sv
// Multi-CDB reservation station: internal lowest-free-slot allocation, operand wakeup
// from NUM_CDB broadcast channels, oldest-ready selection into a registered issue port.
module rs_station_multi #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int OP_W    = 6,
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 2,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic                     clear,
  input  logic                     push_valid,
  output logic                     push_accept,
  input  logic [OP_W-1:0]          push_op,
  input  logic [XLEN-1:0]          push_imm,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [TAG_W-1:0]         push_robpos,
  input  logic [XLEN-1:0]          push_vj,
  input  logic [XLEN-1:0]          push_vk,
  input  logic                     push_qj,
  input  logic                     push_qk,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_pc,
  output logic [TAG_W-1:0]         iss_robpos,
  output logic [XLEN-1:0]          iss_vj,
  output logic [XLEN-1:0]          iss_vk,
  output logic [CNT_W-1:0]         count,
  output logic                     full
);

  // Returns {hit, value}; the lowest matching channel wins.
  function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0]         tag,
                                          input logic [NUM_CDB-1:0]       v,
                                          input logic [NUM_CDB*TAG_W-1:0] t,
                                          input logic [NUM_CDB*XLEN-1:0]  d);
    logic [XLEN:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (v[c] && (t[c*TAG_W +: TAG_W] == tag)) r = {1'b1, d[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [DEPTH-1:0] busy_q, busy_d, qj_q, qj_d, qk_q, qk_d;
  logic [IDX_W-1:0] age_q [DEPTH];
  logic [IDX_W-1:0] age_d [DEPTH];
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [OP_W-1:0]  op_d  [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [XLEN-1:0]  imm_d [DEPTH];
  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [XLEN-1:0]  pc_d  [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH];
  logic [TAG_W-1:0] rob_d [DEPTH];
  logic [XLEN-1:0]  vj_q  [DEPTH];
  logic [XLEN-1:0]  vj_d  [DEPTH];
  logic [XLEN-1:0]  vk_q  [DEPTH];
  logic [XLEN-1:0]  vk_d  [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]  iss_op_q, iss_op_d;
  logic [XLEN-1:0]  iss_imm_q, iss_imm_d, iss_pc_q, iss_pc_d;
  logic [TAG_W-1:0] iss_rob_q, iss_rob_d;
  logic [XLEN-1:0]  iss_vj_q, iss_vj_d, iss_vk_q, iss_vk_d;

  logic             push_fire, iss_load, sel_found;
  logic [IDX_W-1:0] free_idx, sel_idx, sel_age;
  logic [XLEN:0]    push_hit_j, push_hit_k;

  assign push_accept = (count_q != CNT_W'(DEPTH)) && ready && !clear;
  assign push_fire   = push_valid && push_accept;
  assign push_hit_j  = snoop(push_vj[TAG_W-1:0], cdb_valid, cdb_tag, cdb_val);
  assign push_hit_k  = snoop(push_vk[TAG_W-1:0], cdb_valid, cdb_tag, cdb_val);

  // Slot allocation and oldest-ready selection both look at registered state only,
  // so an entry woken this cycle cannot also be selected this cycle.
  always_comb begin
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && !qj_q[i] && !qk_q[i] && (!sel_found || (age_q[i] > sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
    iss_load = sel_found && (!iss_valid_q || iss_ready);
  end

  always_comb begin
    logic [XLEN:0] hit;
    hit    = '0;
    busy_d = busy_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    age_d  = age_q;
    op_d   = op_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    rob_d  = rob_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && qj_q[i]) begin
        hit = snoop(vj_q[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_val);
        if (hit[XLEN]) begin
          qj_d[i] = 1'b0;
          vj_d[i] = hit[XLEN-1:0];
        end
      end
      if (busy_q[i] && qk_q[i]) begin
        hit = snoop(vk_q[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_val);
        if (hit[XLEN]) begin
          qk_d[i] = 1'b0;
          vk_d[i] = hit[XLEN-1:0];
        end
      end
      // Ages stay a dense 0..count-1 ranking: close the gap left by an issued entry.
      if (busy_q[i]) begin
        age_d[i] = age_q[i] + IDX_W'(push_fire) - IDX_W'(iss_load && (age_q[i] > sel_age));
      end
      if (iss_load && (sel_idx == IDX_W'(i))) busy_d[i] = 1'b0;
      if (push_fire && (free_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
        age_d[i]  = '0;
        op_d[i]   = push_op;
        imm_d[i]  = push_imm;
        pc_d[i]   = push_pc;
        rob_d[i]  = push_robpos;
        qj_d[i]   = push_qj && !push_hit_j[XLEN];
        qk_d[i]   = push_qk && !push_hit_k[XLEN];
        vj_d[i]   = (push_qj && push_hit_j[XLEN]) ? push_hit_j[XLEN-1:0] : push_vj;
        vk_d[i]   = (push_qk && push_hit_k[XLEN]) ? push_hit_k[XLEN-1:0] : push_vk;
      end
    end
  end

  always_comb begin
    count_d     = count_q + CNT_W'(push_fire) - CNT_W'(iss_load);
    full_d      = (count_d == CNT_W'(DEPTH));
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_imm_d   = iss_imm_q;
    iss_pc_d    = iss_pc_q;
    iss_rob_d   = iss_rob_q;
    iss_vj_d    = iss_vj_q;
    iss_vk_d    = iss_vk_q;
    if (iss_load) begin
      iss_valid_d = 1'b1;
      iss_op_d    = op_q[sel_idx];
      iss_imm_d   = imm_q[sel_idx];
      iss_pc_d    = pc_q[sel_idx];
      iss_rob_d   = rob_q[sel_idx];
      iss_vj_d    = vj_q[sel_idx];
      iss_vk_d    = vk_q[sel_idx];
    end else if (iss_valid_q && iss_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  // Control state and issue port: reset, then clear, then ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= '0;
      qj_q        <= '0;
      qk_q        <= '0;
      age_q       <= '{default: '0};
      count_q     <= '0;
      full_q      <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      iss_rob_q   <= '0;
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
    end else if (clear) begin
      busy_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      iss_valid_q <= 1'b0;
    end else if (ready) begin
      busy_q      <= busy_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      age_q       <= age_d;
      count_q     <= count_d;
      full_q      <= full_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_imm_q   <= iss_imm_d;
      iss_pc_q    <= iss_pc_d;
      iss_rob_q   <= iss_rob_d;
      iss_vj_q    <= iss_vj_d;
      iss_vk_q    <= iss_vk_d;
    end
  end

  // Entry payload is qualified by busy_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ready && !clear) begin
      op_q  <= op_d;
      imm_q <= imm_d;
      pc_q  <= pc_d;
      rob_q <= rob_d;
      vj_q  <= vj_d;
      vk_q  <= vk_d;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_op     = iss_op_q;
  assign iss_imm    = iss_imm_q;
  assign iss_pc     = iss_pc_q;
  assign iss_robpos = iss_rob_q;
  assign iss_vj     = iss_vj_q;
  assign iss_vk     = iss_vk_q;
  assign count      = count_q;
  assign full       = full_q;

endmodule
